// File: rtl/icache_fetch_responder.sv
// -----------------------------------------------------------------------------
// icache_fetch_responder
//   Responder side of the fetch-stage instruction cache. Accepts 8-byte-aligned
//   dual-instruction fetches through an addr_ok/data_ok handshake and returns
//   the two 32-bit words of the addressed pair. Storage is a direct-mapped cache
//   of SETS lines, 32 bytes (8 words) each. Misses are refilled by a burst read
//   towards the memory bridge; the completed response is bypassed straight out
//   of the refill buffer.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   req, addr             fetch request valid / fetch PC (addr[2:0] ignored)
//   addr_ok               request accepted this cycle
//   data_ok, rdata1/2     response valid, words at pair offsets 0 and 4
//   rd_req, rd_addr       refill burst request, 32-byte aligned line address
//   rd_rdy                refill request accepted
//   ret_valid/last/data   refill beats, word 0 first
// -----------------------------------------------------------------------------
module icache_fetch_responder #(
  parameter int SETS  = 64,
  parameter int IDX_W = $clog2(SETS)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [31:0] addr,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  output logic        rd_req,
  output logic [31:0] rd_addr,
  input  logic        rd_rdy,
  input  logic        ret_valid,
  input  logic        ret_last,
  input  logic [31:0] ret_data
);

  localparam int TAG_W = 32 - 5 - IDX_W;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOOKUP  = 3'd1,
    S_MISS    = 3'd2,
    S_REFILL  = 3'd3,
    S_RESPOND = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [31:3]       req_addr_q, req_addr_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [SETS-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [31:0]       line_q [SETS][8];
  logic [31:0]       buf_q  [8];

  logic              buf_we_s;
  logic              fill_we_s;
  logic [IDX_W-1:0]  idx_s;
  logic [TAG_W-1:0]  tag_s;
  logic [1:0]        pair_s;
  logic              hit_s;
  logic              addr_unused_s;

  // The byte offset inside an instruction pair carries no information here.
  assign addr_unused_s = ^addr[2:0];

  assign idx_s  = req_addr_q[5+IDX_W-1:5];
  assign tag_s  = req_addr_q[31:5+IDX_W];
  assign pair_s = req_addr_q[4:3];
  assign hit_s  = valid_q[idx_s] && (tag_q[idx_s] == tag_s);

  // Next-state, handshake outputs and array write enables.
  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    buf_we_s   = 1'b0;
    fill_we_s  = 1'b0;
    addr_ok    = 1'b0;
    data_ok    = 1'b0;
    rdata1     = 32'h0000_0000;
    rdata2     = 32'h0000_0000;
    rd_req     = 1'b0;
    rd_addr    = 32'h0000_0000;
    if (reset) begin
      state_d = S_IDLE;
      cnt_d   = 3'd0;
      valid_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          addr_ok = req;
          if (req) begin
            state_d    = S_LOOKUP;
            req_addr_d = addr[31:3];
          end else begin
            state_d = S_IDLE;
          end
        end
        S_LOOKUP: begin
          if (hit_s) begin
            data_ok = 1'b1;
            rdata1  = line_q[idx_s][{pair_s, 1'b0}];
            rdata2  = line_q[idx_s][{pair_s, 1'b1}];
            // A hit frees the slot in the same cycle, allowing streaming.
            addr_ok = req;
            if (req) begin
              state_d    = S_LOOKUP;
              req_addr_d = addr[31:3];
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            state_d = S_MISS;
          end
        end
        S_MISS: begin
          rd_req  = 1'b1;
          rd_addr = {req_addr_q[31:5], 5'b00000};
          if (rd_rdy) begin
            state_d = S_REFILL;
            cnt_d   = 3'd0;
          end else begin
            state_d = S_MISS;
          end
        end
        S_REFILL: begin
          if (ret_valid) begin
            buf_we_s = 1'b1;
            cnt_d    = cnt_q + 3'd1;
            if (ret_last) begin
              fill_we_s      = 1'b1;
              valid_d[idx_s] = 1'b1;
              state_d        = S_RESPOND;
            end else begin
              state_d = S_REFILL;
            end
          end else begin
            state_d = S_REFILL;
          end
        end
        S_RESPOND: begin
          // Bypass from the refill buffer; the line array is not read.
          data_ok = 1'b1;
          rdata1  = buf_q[{pair_s, 1'b0}];
          rdata2  = buf_q[{pair_s, 1'b1}];
          addr_ok = req;
          if (req) begin
            state_d    = S_LOOKUP;
            req_addr_d = addr[31:3];
          end else begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      req_addr_q <= '0;
      cnt_q      <= 3'd0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
    end
  end

  // Refill buffer: one word per accepted beat.
  always_ff @(posedge clk) begin
    if (buf_we_s) begin
      buf_q[cnt_q] <= ret_data;
    end
  end

  // Line install: buffered words plus the final beat, written in one cycle.
  always_ff @(posedge clk) begin
    if (fill_we_s) begin
      tag_q[idx_s] <= tag_s;
      for (int w = 0; w < 8; w++) begin
        line_q[idx_s][w] <= (3'(w) == cnt_q) ? ret_data : buf_q[w];
      end
    end
  end

endmodule

// File: tb/tb_icache_fetch_responder.sv
module tb_icache_fetch_responder;

  logic        clk;
  logic        reset;
  logic        req;
  logic [31:0] addr;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_rdy;
  logic        ret_valid;
  logic        ret_last;
  logic [31:0] ret_data;

  int checks;
  int errors;

  // Reference cache contents: per set, whether a line is present and which
  // 32-byte block (addr[31:5]) it holds.
  bit          m_valid [64];
  logic [26:0] m_line  [64];

  icache_fetch_responder #(.SETS(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .addr      (addr),
    .addr_ok   (addr_ok),
    .data_ok   (data_ok),
    .rdata1    (rdata1),
    .rdata2    (rdata2),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_rdy    (rd_rdy),
    .ret_valid (ret_valid),
    .ret_last  (ret_last),
    .ret_data  (ret_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Backing memory: word at byte address a; 0x1000 holds 0x100, 0x1004 0x101...
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a >> 2) - 32'h0000_0300;
  endfunction

  function automatic logic [31:0] exp_w1(input logic [31:0] a);
    return mem({a[31:3], 3'b000});
  endfunction

  function automatic logic [31:0] exp_w2(input logic [31:0] a);
    return mem({a[31:3], 3'b100});
  endfunction

  // Single fetch; the model decides hit or miss and the bench plays memory.
  task automatic fetch(input logic [31:0] a, input int stall, input int gap_max);
    logic [31:0] la;
    int          set;
    bit          exp_hit;
    la      = {a[31:5], 5'b00000};
    set     = int'(a[10:5]);
    exp_hit = m_valid[set] && (m_line[set] == a[31:5]);
    @(posedge clk); #1;
    req = 1'b1; addr = a;
    @(negedge clk);
    checks++;
    if (addr_ok !== 1'b1) begin
      errors++; $display("FAIL accept addr=%h addr_ok=%b exp 1", a, addr_ok);
    end
    @(posedge clk); #1;
    req = 1'b0; addr = $urandom;
    @(negedge clk);
    if (exp_hit) begin
      checks++;
      if (data_ok !== 1'b1 || rdata1 !== exp_w1(a) || rdata2 !== exp_w2(a)) begin
        errors++;
        $display("FAIL hit addr=%h got ok=%b %h %h exp 1 %h %h",
                 a, data_ok, rdata1, rdata2, exp_w1(a), exp_w2(a));
      end
    end else begin
      checks++;
      if (data_ok !== 1'b0 || addr_ok !== 1'b0) begin
        errors++; $display("FAIL miss_lookup addr=%h data_ok=%b addr_ok=%b exp 0 0",
                           a, data_ok, addr_ok);
      end
      for (int s = 0; s <= stall; s++) begin
        @(posedge clk); #1;
        rd_rdy = (s == stall);
        req    = (s != stall);
        addr   = $urandom;
        @(negedge clk);
        checks++;
        if (rd_req !== 1'b1 || rd_addr !== la) begin
          errors++; $display("FAIL rd_req cyc=%0d got %b %h exp 1 %h", s, rd_req, rd_addr, la);
        end
        checks++;
        if (addr_ok !== 1'b0 || data_ok !== 1'b0) begin
          errors++; $display("FAIL miss_quiet cyc=%0d addr_ok=%b data_ok=%b exp 0 0",
                             s, addr_ok, data_ok);
        end
      end
      for (int k = 0; k < 8; k++) begin
        int g;
        g = $urandom_range(gap_max, 0);
        for (int j = 0; j < g; j++) begin
          @(posedge clk); #1;
          rd_rdy = 1'b0; ret_valid = 1'b0; ret_last = 1'b0; ret_data = $urandom;
          @(negedge clk);
          checks++;
          if (data_ok !== 1'b0 || rd_req !== 1'b0) begin
            errors++; $display("FAIL refill_gap data_ok=%b rd_req=%b exp 0 0", data_ok, rd_req);
          end
        end
        @(posedge clk); #1;
        rd_rdy = 1'b0; ret_valid = 1'b1; ret_data = mem(la + 32'(4 * k)); ret_last = (k == 7);
        @(negedge clk);
        checks++;
        if (data_ok !== 1'b0) begin
          errors++; $display("FAIL refill_beat k=%0d data_ok=%b exp 0", k, data_ok);
        end
      end
      @(posedge clk); #1;
      ret_valid = 1'b0; ret_last = 1'b0;
      @(negedge clk);
      checks++;
      if (data_ok !== 1'b1 || rdata1 !== exp_w1(a) || rdata2 !== exp_w2(a)) begin
        errors++;
        $display("FAIL respond addr=%h got ok=%b %h %h exp 1 %h %h",
                 a, data_ok, rdata1, rdata2, exp_w1(a), exp_w2(a));
      end
      m_valid[set] = 1'b1;
      m_line[set]  = a[31:5];
    end
  endtask

  // Back-to-back requests, all of which must hit.
  task automatic stream(input logic [31:0] q[$]);
    @(posedge clk); #1;
    req = 1'b1; addr = q[0];
    @(negedge clk);
    checks++;
    if (addr_ok !== 1'b1) begin
      errors++; $display("FAIL stream_first addr_ok=%b exp 1", addr_ok);
    end
    for (int i = 1; i <= q.size(); i++) begin
      @(posedge clk); #1;
      if (i < q.size()) begin
        req = 1'b1; addr = q[i];
      end else begin
        req = 1'b0; addr = $urandom;
      end
      @(negedge clk);
      checks++;
      if (data_ok !== 1'b1 || rdata1 !== exp_w1(q[i-1]) || rdata2 !== exp_w2(q[i-1])) begin
        errors++;
        $display("FAIL stream_data i=%0d got ok=%b %h %h exp 1 %h %h", i - 1,
                 data_ok, rdata1, rdata2, exp_w1(q[i-1]), exp_w2(q[i-1]));
      end
      checks++;
      if (addr_ok !== (i < q.size())) begin
        errors++; $display("FAIL stream_accept i=%0d addr_ok=%b exp %b", i, addr_ok, (i < q.size()));
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 1'b1; addr = 32'h0000_1008;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (addr_ok !== 1'b0 || data_ok !== 1'b0 || rd_req !== 1'b0 || rd_addr !== 32'h0 ||
        rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
      errors++; $display("FAIL reset_outputs addr_ok=%b data_ok=%b rd_req=%b rd_addr=%h r1=%h r2=%h exp all 0",
                         addr_ok, data_ok, rd_req, rd_addr, rdata1, rdata2);
    end
    @(posedge clk); #1;
    reset = 1'b0; req = 1'b0;
    @(negedge clk);
    checks++;
    if (addr_ok !== 1'b0 || data_ok !== 1'b0 || rd_req !== 1'b0 || rdata1 !== 32'h0) begin
      errors++; $display("FAIL idle_outputs addr_ok=%b data_ok=%b rd_req=%b r1=%h exp 0",
                         addr_ok, data_ok, rd_req, rdata1);
    end
    for (int s = 0; s < 64; s++) m_valid[s] = 1'b0;
  endtask

  task automatic test_cold_miss();
    fetch(32'h0000_1008, 0, 0);
  endtask

  task automatic test_hit_stream();
    logic [31:0] q[$];
    q = '{32'h0000_1000, 32'h0000_1008, 32'h0000_1010, 32'h0000_1018};
    stream(q);
  endtask

  task automatic test_conflict();
    fetch(32'h0000_1000, 0, 1);
    fetch(32'h0000_1800, 0, 1);
    fetch(32'h0000_1000, 0, 1);
  endtask

  task automatic test_backpressure();
    fetch(32'h0000_2040, 5, 0);
    fetch(32'h0000_2058, 0, 0);
  endtask

  task automatic test_reset_refill();
    logic [31:0] a;
    a = 32'h0000_3020;
    @(posedge clk); #1;
    req = 1'b1; addr = a;
    @(posedge clk); #1;
    req = 1'b0; rd_rdy = 1'b1;
    @(posedge clk); #1;
    rd_rdy = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      ret_valid = 1'b1; ret_last = 1'b0; ret_data = mem(32'h0000_3000 + 32'(4 * k));
      @(posedge clk); #1;
    end
    reset = 1'b1; ret_data = $urandom;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      ret_valid = 1'b1; ret_last = (c == 3); ret_data = $urandom;
      @(negedge clk);
      checks++;
      if (data_ok !== 1'b0 || rd_req !== 1'b0 || addr_ok !== 1'b0) begin
        errors++; $display("FAIL post_reset_stray c=%0d data_ok=%b rd_req=%b addr_ok=%b exp 0 0 0",
                           c, data_ok, rd_req, addr_ok);
      end
      @(posedge clk); #1;
    end
    ret_valid = 1'b0; ret_last = 1'b0;
    for (int s = 0; s < 64; s++) m_valid[s] = 1'b0;
    fetch(a, 1, 1);
  endtask

  task automatic test_stray();
    fetch(32'h0000_4000, 0, 0);
    ret_valid = 1'b1; ret_last = 1'b1; ret_data = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #1;
    fetch(32'h0000_4008, 0, 0);
    fetch(32'h0000_4018, 0, 0);
    ret_valid = 1'b0; ret_last = 1'b0;
    fetch(32'h0000_4010, 0, 0);
  endtask

  task automatic test_random();
    logic [20:0] tags [3];
    logic [5:0]  idxs [4];
    logic [31:0] q[$];
    tags = '{21'h00002, 21'h00003, 21'h1ABCD};
    idxs = '{6'd0, 6'd1, 6'd2, 6'd63};
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      a = {tags[$urandom_range(2, 0)], idxs[$urandom_range(3, 0)],
           2'($urandom_range(3, 0)), 3'($urandom_range(7, 0))};
      fetch(a, $urandom_range(3, 0), $urandom_range(2, 0));
    end
    for (int s = 0; s < 64; s++) begin
      if (m_valid[s]) q.push_back({m_line[s], 2'($urandom_range(3, 0)), 3'b000});
    end
    for (int s = 0; s < 64; s++) begin
      if (m_valid[s]) q.push_back({m_line[s], 2'($urandom_range(3, 0)), 3'b100});
    end
    if (q.size() > 0) stream(q);
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; req = 1'b0; addr = 32'h0;
    rd_rdy = 1'b0; ret_valid = 1'b0; ret_last = 1'b0; ret_data = 32'h0;
    test_reset();
    test_cold_miss();
    test_hit_stream();
    test_conflict();
    test_backpressure();
    test_reset_refill();
    test_stray();
    test_random();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
